jk_cmd_seq: RTL and testbench

Command sequencer that drives the J/K inputs of a bank of `WIDTH` JK flip-flops and reads their `q` outputs back. It sits directly upstream of the JK flip-flop bank and turns valid/ready commands (hold/reset/set/toggle, masked, repeated) into single-cycle J/K pulses. After each pulse it verifies the resulting `q` and reports completion or error.

---
 rtl/jk_cmd_seq_if.sv | 27 ++
 rtl/jk_cmd_seq.sv | 149 ++++++++++++++
 tb/tb_jk_cmd_seq.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/jk_cmd_seq_if.sv
// rtl/jk_cmd_seq_if.sv - command and JK flop-bank bus between a command source and jk_cmd_seq.
interface jk_cmd_seq_if #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic [1:0]       cmd_op;
  logic [WIDTH-1:0] cmd_mask;
  logic [CNT_W-1:0] cmd_rpt;
  logic [WIDTH-1:0] j;
  logic [WIDTH-1:0] k;
  logic [WIDTH-1:0] q;
  logic             busy;
  logic             done;
  logic             err;

  modport slave (
    input  cmd_valid, cmd_op, cmd_mask, cmd_rpt, q,
    output cmd_ready, j, k, busy, done, err
  );

  modport master (
    output cmd_valid, cmd_op, cmd_mask, cmd_rpt, q,
    input  cmd_ready, j, k, busy, done, err
  );
endinterface

// File: rtl/jk_cmd_seq.sv
// rtl/jk_cmd_seq.sv - JK flop-bank command sequencer; JK_CMD_SEQ_CHECK_EN adds per-pulse q verify and err.
module jk_cmd_seq #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8
) (
  input  logic         clk,
  input  logic         rst,
  jk_cmd_seq_if.slave  bus
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_DRIVE = 2'd1;
`ifdef JK_CMD_SEQ_CHECK_EN
  localparam logic [1:0] S_CHECK = 2'd2;
`endif
  localparam logic [CNT_W-1:0] RPT_ONE = CNT_W'(1);

  logic [1:0]       state_q, state_d;
  logic [1:0]       op_q, op_d;
  logic [WIDTH-1:0] mask_q, mask_d;
  logic [CNT_W-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] j_q, j_d;
  logic [WIDTH-1:0] k_q, k_d;
  logic             done_q, done_d;
`ifdef JK_CMD_SEQ_CHECK_EN
  logic [WIDTH-1:0] exp_q, exp_d;
  logic             err_q, err_d;
`else
  logic             unused_q;
  assign unused_q = ^bus.q;
`endif

  // Packed {j, k} for an op: set drives J, reset drives K, toggle drives both.
  function automatic logic [2*WIDTH-1:0] drive_jk(input logic [1:0] op, input logic [WIDTH-1:0] mask);
    drive_jk = {({WIDTH{op[1]}} & mask), ({WIDTH{op[0]}} & mask)};
  endfunction

`ifdef JK_CMD_SEQ_CHECK_EN
  function automatic logic [WIDTH-1:0] exp_of(input logic [1:0] op, input logic [WIDTH-1:0] mask,
                                               input logic [WIDTH-1:0] qv);
    case (op)
      2'b01:   exp_of = qv & ~mask;
      2'b10:   exp_of = qv | mask;
      2'b11:   exp_of = qv ^ mask;
      default: exp_of = qv;
    endcase
  endfunction
`endif

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    mask_d  = mask_q;
    rem_d   = rem_q;
    j_d     = '0;
    k_d     = '0;
    done_d  = 1'b0;
`ifdef JK_CMD_SEQ_CHECK_EN
    exp_d   = exp_q;
    err_d   = 1'b0;
`endif
    case (state_q)
      S_IDLE: begin
        if (bus.cmd_valid) begin
          op_d       = bus.cmd_op;
          mask_d     = bus.cmd_mask;
          rem_d      = (bus.cmd_rpt == '0) ? RPT_ONE : bus.cmd_rpt;
          {j_d, k_d} = drive_jk(bus.cmd_op, bus.cmd_mask);
          state_d    = S_DRIVE;
        end
      end
`ifdef JK_CMD_SEQ_CHECK_EN
      S_DRIVE: begin
        // q sampled here is still the pre-pulse value; the bank updates on this same edge.
        exp_d   = exp_of(op_q, mask_q, bus.q);
        state_d = S_CHECK;
      end
      S_CHECK: begin
        if (bus.q != exp_q) begin
          err_d   = 1'b1;
          done_d  = 1'b1;
          rem_d   = '0;
          state_d = S_IDLE;
        end else begin
          rem_d = rem_q - RPT_ONE;
          if (rem_q == RPT_ONE) begin
            done_d  = 1'b1;
            state_d = S_IDLE;
          end else begin
            {j_d, k_d} = drive_jk(op_q, mask_q);
            state_d    = S_DRIVE;
          end
        end
      end
`else
      S_DRIVE: begin
        rem_d = rem_q - RPT_ONE;
        if (rem_q == RPT_ONE) begin
          done_d  = 1'b1;
          state_d = S_IDLE;
        end else begin
          {j_d, k_d} = drive_jk(op_q, mask_q);
        end
      end
`endif
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      op_q    <= 2'b00;
      mask_q  <= '0;
      rem_q   <= '0;
      j_q     <= '0;
      k_q     <= '0;
      done_q  <= 1'b0;
`ifdef JK_CMD_SEQ_CHECK_EN
      exp_q   <= '0;
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      mask_q  <= mask_d;
      rem_q   <= rem_d;
      j_q     <= j_d;
      k_q     <= k_d;
      done_q  <= done_d;
`ifdef JK_CMD_SEQ_CHECK_EN
      exp_q   <= exp_d;
      err_q   <= err_d;
`endif
    end
  end

  assign bus.cmd_ready = (state_q == S_IDLE);
  assign bus.busy      = (state_q != S_IDLE);
  assign bus.j         = j_q;
  assign bus.k         = k_q;
  assign bus.done      = done_q;
`ifdef JK_CMD_SEQ_CHECK_EN
  assign bus.err       = err_q;
`else
  assign bus.err       = 1'b0;
`endif

endmodule

// File: tb/tb_jk_cmd_seq.sv
// tb/tb_jk_cmd_seq.sv - table-driven scoreboard bench for jk_cmd_seq with a JK flop-bank model.
module tb_jk_cmd_seq;

`ifdef JK_CMD_SEQ_CHECK_EN
  localparam int P   = 2;
  localparam bit CHK = 1'b1;
`else
  localparam int P   = 1;
  localparam bit CHK = 1'b0;
`endif

  logic clk;
  logic rst;
  logic [3:0] bank_q;
  logic [3:0] stuck;

  jk_cmd_seq_if #(.WIDTH(4), .CNT_W(8)) bus ();

  jk_cmd_seq #(.WIDTH(4), .CNT_W(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // JK flop bank; stuck bits read back as 0 regardless of the flop state.
  assign bus.q = bank_q & ~stuck;
  always @(posedge clk) begin
    if (!rst) bank_q <= 4'b0000;
    else bank_q <= (bank_q & ~(bus.j | bus.k)) | (bus.j & ~bus.k) | (bus.j & bus.k & ~bank_q);
  end

  typedef struct packed {
    logic [1:0] op;
    logic [3:0] mask;
    logic [7:0] rpt;
    logic [3:0] q_exp;
  } vec_t;

  typedef struct {
    logic [3:0] q;
    logic       err;
    int         lat;
    int         pulses;
    logic [3:0] j;
    logic [3:0] k;
  } exp_t;

  exp_t sb[$];
  vec_t vecs[9];
  int   n_pass = 0;
  int   n_total = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_total++;
    if (act === req) n_pass++;
    else $display("FAIL %s actual=%0h required=%0h", nm, act, req);
  endtask

  function automatic exp_t mk_exp(input logic [1:0] op, input logic [3:0] mask,
                                  input logic [7:0] rpt, input logic [3:0] qv);
    exp_t e;
    int n;
    n        = (rpt == 8'd0) ? 1 : int'(rpt);
    e.q      = qv;
    e.err    = 1'b0;
    e.lat    = P * n;
    e.pulses = (op == 2'b00) ? 0 : n;
    e.j      = op[1] ? mask : 4'b0000;
    e.k      = op[0] ? mask : 4'b0000;
    return e;
  endfunction

  task automatic wait_ready(input string nm);
    int cnt = 0;
    while (!bus.cmd_ready && cnt < 100) begin
      @(negedge clk);
      cnt++;
    end
    if (!bus.cmd_ready) check({nm, " accept_timeout"}, 32'(bus.cmd_ready), 32'd1);
  endtask

  task automatic run_cmd(input string nm, input logic [1:0] op, input logic [3:0] mask,
                         input logic [7:0] rpt, input exp_t e);
    exp_t x;
    int idx, pulses, badjk;
    @(negedge clk);
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = op;
    bus.cmd_mask  = mask;
    bus.cmd_rpt   = rpt;
    wait_ready(nm);
    sb.push_back(e);
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    check({nm, " busy"}, 32'(bus.busy), 32'd1);
    idx = 0; pulses = 0; badjk = 0;
    while (!bus.done && idx < 600) begin
      if (bus.j != 4'b0000 || bus.k != 4'b0000) begin
        pulses++;
        if (bus.j != e.j || bus.k != e.k) badjk++;
      end
      @(negedge clk);
      idx++;
    end
    x = sb.pop_front();
    check({nm, " done_latency"}, 32'(idx), 32'(x.lat));
    check({nm, " pulses"}, 32'(pulses), 32'(x.pulses));
    check({nm, " jk_value_errs"}, 32'(badjk), 32'd0);
    check({nm, " err"}, 32'(bus.err), 32'(x.err));
    check({nm, " q"}, 32'(bus.q), 32'(x.q));
    check({nm, " ready_at_done"}, 32'(bus.cmd_ready), 32'd1);
  endtask

  initial begin
    exp_t e;
    int idx, cnt;
    logic saw_done;

    vecs[0] = '{2'b10, 4'b0101, 8'd1, 4'b0101};
    vecs[1] = '{2'b11, 4'b0011, 8'd3, 4'b0110};
    vecs[2] = '{2'b01, 4'b1111, 8'd0, 4'b0000};
    vecs[3] = '{2'b10, 4'b1010, 8'd2, 4'b1010};
    vecs[4] = '{2'b00, 4'b1111, 8'd4, 4'b1010};
    vecs[5] = '{2'b11, 4'b1111, 8'd2, 4'b1010};
    vecs[6] = '{2'b11, 4'b1000, 8'd1, 4'b0010};
    vecs[7] = '{2'b10, 4'b1111, 8'd0, 4'b1111};
    vecs[8] = '{2'b01, 4'b0110, 8'd3, 4'b1001};

    rst = 1'b0;
    stuck = 4'b0000;
    bus.cmd_valid = 1'b0;
    bus.cmd_op = 2'b00;
    bus.cmd_mask = 4'b0000;
    bus.cmd_rpt = 8'd0;
    repeat (3) @(negedge clk);
    check("reset j", 32'(bus.j), 32'd0);
    check("reset k", 32'(bus.k), 32'd0);
    check("reset ready", 32'(bus.cmd_ready), 32'd1);
    check("reset busy", 32'(bus.busy), 32'd0);
    check("reset done", 32'(bus.done), 32'd0);
    check("reset err", 32'(bus.err), 32'd0);
    rst = 1'b1;

    for (int i = 0; i < 9; i++) begin
      e = mk_exp(vecs[i].op, vecs[i].mask, vecs[i].rpt, vecs[i].q_exp);
      run_cmd($sformatf("vec%0d", i), vecs[i].op, vecs[i].mask, vecs[i].rpt, e);
    end

    // Back-to-back with cmd_valid held: the second command lands on the edge after done.
    @(negedge clk);
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = 2'b10;
    bus.cmd_mask  = 4'b0001;
    bus.cmd_rpt   = 8'd2;
    wait_ready("b2b");
    @(negedge clk);
    idx = 0;
    while (!bus.done && idx < 100) begin
      @(negedge clk);
      idx++;
    end
    check("b2b first_done", 32'(idx), 32'(2 * P));
    check("b2b q_first", 32'(bus.q), 32'h9);
    bus.cmd_mask = 4'b0110;
    bus.cmd_rpt  = 8'd1;
    @(negedge clk);
    check("b2b second_busy", 32'(bus.busy), 32'd1);
    check("b2b second_j", 32'(bus.j), 32'h6);
    bus.cmd_valid = 1'b0;
    cnt = 0;
    while (!bus.done && cnt < 100) begin
      @(negedge clk);
      cnt++;
    end
    check("b2b second_done", 32'(cnt), 32'(P));
    check("b2b q_second", 32'(bus.q), 32'hf);

    // Stuck-at-0 bit 0: with verify, the first pulse is flagged and the rest aborted.
    e = mk_exp(2'b01, 4'b1111, 8'd1, 4'b0000);
    run_cmd("clr", 2'b01, 4'b1111, 8'd1, e);
    stuck = 4'b0001;
    e = mk_exp(2'b10, 4'b0001, 8'd4, 4'b0000);
    if (CHK) begin
      e.lat = 2;
      e.pulses = 1;
      e.err = 1'b1;
    end
    run_cmd("fault", 2'b10, 4'b0001, 8'd4, e);
    @(negedge clk);
    check("fault idle_after", 32'(bus.busy), 32'd0);
    check("fault jk_after", 32'({bus.j, bus.k}), 32'd0);
    check("fault ready_after", 32'(bus.cmd_ready), 32'd1);
    stuck = 4'b0000;

    // Asynchronous reset in the middle of a repeated toggle.
    @(negedge clk);
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = 2'b11;
    bus.cmd_mask  = 4'b1111;
    bus.cmd_rpt   = 8'd5;
    wait_ready("midrst");
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("midrst busy_before", 32'(bus.busy), 32'd1);
    #2 rst = 1'b0;
    #1;
    check("midrst j", 32'(bus.j), 32'd0);
    check("midrst k", 32'(bus.k), 32'd0);
    check("midrst busy", 32'(bus.busy), 32'd0);
    check("midrst ready", 32'(bus.cmd_ready), 32'd1);
    saw_done = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (bus.done) saw_done = 1'b1;
    end
    rst = 1'b1;
    repeat (12) begin
      @(negedge clk);
      if (bus.done) saw_done = 1'b1;
    end
    check("midrst no_done", 32'(saw_done), 32'd0);
    e = mk_exp(2'b10, 4'b1111, 8'd1, 4'b1111);
    run_cmd("after_rst", 2'b10, 4'b1111, 8'd1, e);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
